tx_len_pattern_gen: RTL and testbench
=====================================

# tx_len_pattern_gen

Parametrised length-driven test-stream source for the USB FIFO example designs. Receives a command header on an 8-bit AXI-stream slave: one mode byte, then a little-endian byte count. It then emits exactly that many payload bytes on a configurable-width AXI-stream master, with per-byte tkeep and tlast. The block sits between the FIFO receive stream and the FIFO transmit stream in the mass-transfer example tops, and is used for throughput and integrity tests.

## Interface
- OBYTES, default 4: output width in bytes; legal values 1, 2, 4, 8.
- LEN_BYTES, default 4: header length field size in bytes, 1..4; max transfer (2^(8*LEN_BYTES))-1 bytes.

- rstn  input  1  asynchronous reset, active-low
- clk  input  1  clock
- i_tready  output  1  header byte accept
- i_tvalid  input  1  header byte valid
- i_tdata  input  8  header byte
- o_tready  input  1  downstream ready
- o_tvalid  output  1  payload beat valid
- o_tdata  output  8*OBYTES  payload; lane k is bits [8k+7:8k], and lane 0 holds the lowest offset
- o_tkeep  output  OBYTES  per-lane byte valid
- o_tlast  output  1  final beat of transfer

## Operation
- States:
  - HDR_MODE: accept the mode byte; latch bit0 as pattern select; bits[7:1] are ignored.
  - HDR_LEN: accept LEN_BYTES bytes, least significant byte first; a byte index counter selects the target byte of `remain`.
  - TX: emit payload beats.
- A header byte is taken only on i_tvalid & i_tready. i_tready = 1 in HDR_MODE and HDR_LEN, 0 in TX.
- On the last length byte:
  - If the assembled length (including the current i_tdata) is 0, go to HDR_MODE. No beat is emitted.
  - Otherwise go to TX with `remain` = length, `offset` = 0 (8-bit), and `lfsr` = 8'h01.
- In TX, a beat transfers on o_tvalid & o_tready.
  - Lane k is valid iff k < remain, so o_tkeep = lanes 0..min(remain,OBYTES)-1.
  - o_tlast = (remain <= OBYTES).
  - Invalid lanes carry 8'h00.
- Pattern 0 (incrementing): byte at transfer offset j = j mod 256, i.e. lane k = (offset + k)[7:0].
- Pattern 1 (LFSR, see Configuration): 8-bit Galois LFSR with step s' = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00).
  - The byte at offset 0 is 8'h01, and each subsequent byte is the next step.
  - Lane k = lfsr stepped k times. This is combinational, OBYTES-1 steps deep.
- On each beat handshake:
  - `offset` += OBYTES (mod 256).
  - `lfsr` advances OBYTES steps.
  - If remain <= OBYTES, go to HDR_MODE; otherwise remain -= OBYTES.
- o_tready low holds o_tdata, o_tkeep and o_tlast stable while o_tvalid = 1.
- Reset asserted at any time (including mid-transfer) returns the block to HDR_MODE and aborts the transfer with no tlast. There is no partial-header recovery.

## Timing
- Reset values:
  - state = HDR_MODE, remain = 0, offset = 0, lfsr = 8'h01.
  - i_tready = 1.
  - o_tvalid = 0, o_tdata = 0, o_tkeep = 0, o_tlast = 0.
- All outputs are decoded from registers only; there is no combinational path from inputs to outputs.
- Header accepts one byte per clk.
- o_tvalid rises on the cycle after the last length byte is accepted (non-zero length).
- Payload throughput is 1 beat/clk while o_tready = 1.
- i_tready rises on the cycle after the tlast beat handshake, or after a zero-length header's last byte.
- Whenever o_tvalid = 0, o_tdata, o_tkeep and o_tlast are forced to 0.

## Configuration
- TX_LEN_PATTERN_LFSR_EN:
  - Defined: mode bit0 = 1 selects the LFSR pattern.
  - Undefined: the LFSR logic is not built, and mode bit0 is ignored (always incrementing).

## Test plan
- OBYTES=4, LEN_BYTES=4, header 00 06 00 00 00 ->
  - beat 0: o_tdata=32'h03020100, tkeep 1111, tlast 0.
  - beat 1: o_tdata=32'h00000504, tkeep 0011, tlast 1.
  - then i_tready=1.
- LFSR build, header 01 05 00 00 00 ->
  - beat 0: 32'h2E5CB801, tkeep 1111.
  - beat 1: lane0=8'h17, tkeep 0001, tlast 1.
- Zero length: header 00 00 00 00 00 -> o_tvalid never asserts; i_tready stays 1 and the next header is accepted normally.
- Wrap: header 00 04 01 00 00 (260 bytes) -> 65 beats; beat 64 = 32'h03020100, tkeep 1111, tlast 1.
- Backpressure: random o_tready and i_tvalid gaps -> byte stream identical to the no-stall run; outputs stable while stalled.
- Reset mid-TX after 2 beats -> o_tvalid=0 and i_tready=1 next cycle; a fresh header 00 02 00 00 00 yields a single beat of 32'h00000100 with tkeep 0011 and tlast 1.

Source files
------------

// File: rtl/tx_len_pattern_gen.sv
// Length-driven test-stream source: takes a mode byte plus a little-endian byte count, then emits that many
// payload bytes (incrementing, or LFSR when built with TX_LEN_PATTERN_LFSR_EN) on an OBYTES-wide AXI stream.
module tx_len_pattern_gen #(
    parameter int OBYTES    = 4,
    parameter int LEN_BYTES = 4
) (
    input  logic                  rstn,
    input  logic                  clk,
    output logic                  i_tready,
    input  logic                  i_tvalid,
    input  logic [7:0]            i_tdata,
    input  logic                  o_tready,
    output logic                  o_tvalid,
    output logic [8*OBYTES-1:0]   o_tdata,
    output logic [OBYTES-1:0]     o_tkeep,
    output logic                  o_tlast
);

    localparam int RW = 8 * LEN_BYTES;
    localparam int IW = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;

    typedef enum logic [1:0] {
        HDR_MODE = 2'd0,
        HDR_LEN  = 2'd1,
        TX       = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [RW-1:0]   r_remain;
    logic [RW-1:0]   w_len;
    logic [IW-1:0]   r_idx;
    logic [7:0]      r_offset;
    logic            w_hdr_last;
    logic            w_beat_last;

    assign w_hdr_last  = (r_idx == IW'(LEN_BYTES - 1));
    assign w_beat_last = (r_remain <= RW'(OBYTES));

    // Length as it will stand once the current header byte is merged in; used for the zero-length test.
    always_comb begin
        w_len = r_remain;
        for (int b = 0; b < LEN_BYTES; b++) begin
            if (r_idx == IW'(b)) begin
                w_len[8*b +: 8] = i_tdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= HDR_MODE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HDR_MODE: if (i_tvalid) w_state_next = HDR_LEN;
            HDR_LEN:  if (i_tvalid && w_hdr_last) w_state_next = (w_len == '0) ? HDR_MODE : TX;
            TX:       if (o_tready && w_beat_last) w_state_next = HDR_MODE;
            default:  w_state_next = HDR_MODE;
        endcase
    end

    // Counters are cleared while idling in HDR_MODE, so TX always starts from offset 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_remain <= '0;
            r_idx    <= '0;
            r_offset <= '0;
        end else begin
            case (r_state)
                HDR_MODE: begin
                    r_remain <= '0;
                    r_idx    <= '0;
                    r_offset <= '0;
                end
                HDR_LEN: begin
                    if (i_tvalid) begin
                        r_remain <= w_len;
                        r_idx    <= w_hdr_last ? '0 : r_idx + IW'(1);
                    end
                end
                TX: begin
                    if (o_tready) begin
                        r_offset <= r_offset + 8'(OBYTES);
                        r_remain <= w_beat_last ? '0 : r_remain - RW'(OBYTES);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TX_LEN_PATTERN_LFSR_EN
    logic       r_mode;
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_chain [0:OBYTES];

    assign w_lfsr_chain[0] = r_lfsr;

    generate
        for (genvar gi = 0; gi < OBYTES; gi++) begin : lfsr_step_g
            assign w_lfsr_chain[gi+1] = {1'b0, w_lfsr_chain[gi][7:1]} ^ (w_lfsr_chain[gi][0] ? 8'hB8 : 8'h00);
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode <= 1'b0;
            r_lfsr <= 8'h01;
        end else begin
            if (r_state == HDR_MODE) begin
                r_lfsr <= 8'h01;
                if (i_tvalid) r_mode <= i_tdata[0];
            end else if (r_state == TX && o_tready) begin
                r_lfsr <= w_lfsr_chain[OBYTES];
            end
        end
    end
`endif

    assign o_tvalid = (r_state == TX);
    assign i_tready = (r_state != TX);
    assign o_tlast  = o_tvalid && w_beat_last;

    generate
        for (genvar gi = 0; gi < OBYTES; gi++) begin : lane_g
            logic [7:0] w_pat;
`ifdef TX_LEN_PATTERN_LFSR_EN
            assign w_pat = r_mode ? w_lfsr_chain[gi] : r_offset + 8'(gi);
`else
            assign w_pat = r_offset + 8'(gi);
`endif
            assign o_tkeep[gi]         = o_tvalid && (r_remain > RW'(gi));
            assign o_tdata[8*gi +: 8]  = o_tkeep[gi] ? w_pat : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_tx_len_pattern_gen.sv
// Randomized bench for tx_len_pattern_gen: expected payload is a per-transfer byte list built from the
// pattern rules and sliced into beats; header gaps and o_tready stalls are randomized.
module tb_tx_len_pattern_gen;

    localparam int OBYTES    = 4;
    localparam int LEN_BYTES = 4;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                i_tready;
    logic                i_tvalid = 1'b0;
    logic [7:0]          i_tdata = 8'h00;
    logic                o_tready = 1'b0;
    logic                o_tvalid;
    logic [8*OBYTES-1:0] o_tdata;
    logic [OBYTES-1:0]   o_tkeep;
    logic                o_tlast;

    int n_tests = 0;
    int n_fail  = 0;

    tx_len_pattern_gen #(.OBYTES(OBYTES), .LEN_BYTES(LEN_BYTES)) dut (
        .rstn     (rstn),
        .clk      (clk),
        .i_tready (i_tready),
        .i_tvalid (i_tvalid),
        .i_tdata  (i_tdata),
        .o_tready (o_tready),
        .o_tvalid (o_tvalid),
        .o_tdata  (o_tdata),
        .o_tkeep  (o_tkeep),
        .o_tlast  (o_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One header + payload transfer. abort_after >= 0 pulses reset once that many beats have gone out.
    task automatic run_xfer(input logic [7:0] mode, input int len, input int stall_pct, input int abort_after);
        logic [7:0]          exp_q[$];
        logic [7:0]          s;
        logic [7:0]          hb;
        logic [8*OBYTES-1:0] ed;
        logic [OBYTES-1:0]   ek;
        logic                el;
        bit                  use_lfsr;
        int                  beat;
        int                  cyc;

        use_lfsr = 1'b0;
`ifdef TX_LEN_PATTERN_LFSR_EN
        use_lfsr = mode[0];
`endif
        s = 8'h01;
        for (int j = 0; j < len; j++) begin
            exp_q.push_back(use_lfsr ? s : 8'(j));
            s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
        end

        for (int b = 0; b <= LEN_BYTES; b++) begin
            if (b == 0) hb = mode;
            else        hb = 8'(len >> (8 * (b - 1)));
            while ($urandom_range(99) < stall_pct) begin
                i_tvalid = 1'b0;
                i_tdata  = 8'($urandom);
                @(posedge clk); #1;
            end
            check("hdr_tready", i_tready, 1);
            check("hdr_tvalid_low", o_tvalid, 0);
            i_tvalid = 1'b1;
            i_tdata  = hb;
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0;

        if (len == 0) begin
            repeat (5) begin
                check("zero_tvalid", o_tvalid, 0);
                check("zero_tready", i_tready, 1);
                @(posedge clk); #1;
            end
            $display("[TB] xfer mode=%02h len=%0d beats=0", mode, len);
            return;
        end

        check("first_tvalid", o_tvalid, 1);
        check("tx_tready_low", i_tready, 0);
        beat = 0;
        cyc  = 0;
        while (beat * OBYTES < len) begin
            if (cyc > 4 * len + 200) begin
                check("beat_timeout", 0, 1);
                break;
            end
            if (abort_after >= 0 && beat == abort_after) begin
                o_tready = 1'b0;
                rstn     = 1'b0;
                @(posedge clk); #1;
                check("rst_tvalid", o_tvalid, 0);
                check("rst_tready", i_tready, 1);
                check("rst_tdata", o_tdata, 0);
                check("rst_tlast", o_tlast, 0);
                rstn = 1'b1;
                @(posedge clk); #1;
                check("post_rst_tvalid", o_tvalid, 0);
                check("post_rst_tready", i_tready, 1);
                $display("[TB] xfer mode=%02h len=%0d aborted after %0d beats", mode, len, beat);
                return;
            end
            o_tready = ($urandom_range(99) >= stall_pct);
            ed = '0;
            ek = '0;
            for (int k = 0; k < OBYTES; k++) begin
                if (beat * OBYTES + k < len) begin
                    ed[8*k +: 8] = exp_q[beat * OBYTES + k];
                    ek[k]        = 1'b1;
                end
            end
            el = ((len - beat * OBYTES) <= OBYTES);
            check("beat_tvalid", o_tvalid, 1);
            check("beat_tdata", o_tdata, ed);
            check("beat_tkeep", o_tkeep, ek);
            check("beat_tlast", o_tlast, el);
            if (o_tready) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        o_tready = 1'b0;
        check("end_tvalid", o_tvalid, 0);
        check("end_tready", i_tready, 1);
        check("end_tdata", o_tdata, 0);
        $display("[TB] xfer mode=%02h len=%0d beats=%0d", mode, len, beat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_i_tready", i_tready, 1);
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_o_tkeep", o_tkeep, 0);
        check("rst_o_tlast", o_tlast, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_i_tready", i_tready, 1);
        check("idle_o_tvalid", o_tvalid, 0);

        run_xfer(8'h00, 6, 0, -1);
        run_xfer(8'h01, 5, 0, -1);
        run_xfer(8'h00, 0, 0, -1);
        run_xfer(8'h00, 3, 0, -1);
        run_xfer(8'h00, 260, 0, -1);
        run_xfer(8'h01, 23, 40, -1);
        run_xfer(8'h00, 40, 0, 2);
        run_xfer(8'h00, 2, 0, -1);
        for (int i = 0; i < 14; i++) begin
            run_xfer(8'($urandom), int'($urandom_range(0, 70)), int'($urandom_range(0, 50)), -1);
        end
        run_xfer(8'h01, 300, 30, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
